// File: rtl/sn_to_binary_accum_if.sv
// Handshake/result bundle for sn_to_binary_accum.
//   master : upstream driver (bitstream, window control, result consumer)
//   slave  : the accumulator (drives busy and the result registers)
interface sn_to_binary_accum_if;
   logic       sn_bit;
   logic       sn_valid;
   logic       start;
   logic       abort;
   logic [1:0] win_sel;
   logic       cont;
   logic       result_ack;
   logic       busy;
   logic       result_valid;
   logic [6:0] ones_count;
   logic [7:0] bipolar;
   logic [3:0] prob4;
   logic       overrun;

   modport master (
      output sn_bit, sn_valid, start, abort, win_sel, cont, result_ack,
      input  busy, result_valid, ones_count, bipolar, prob4, overrun
   );

   modport slave (
      input  sn_bit, sn_valid, start, abort, win_sel, cont, result_ack,
      output busy, result_valid, ones_count, bipolar, prob4, overrun
   );
endinterface

// File: rtl/sn_to_binary_accum.sv
// Stochastic bitstream to binary converter.
// Counts the 1s in a window of N = 8 << win_sel valid samples and publishes
// the count, its bipolar value (2*ones - N) and a 4-bit probability.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active HIGH despite the name
//   bus   : slave side of sn_to_binary_accum_if
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | counting valid samples of the current window
module sn_to_binary_accum (
   input  logic                    clk,
   input  logic                    rst_n,
   sn_to_binary_accum_if.slave     bus
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t     state, state_nxt;
   logic [1:0] win_q;
   logic       cont_q;
   logic [6:0] sample_cnt;
   logic [6:0] ones_cnt;
   logic       arm, clr, inc, load;

   logic [6:0] ones_q;
   logic [7:0] bipolar_q;
   logic [3:0] prob4_q;
   logic       result_valid_q;
   logic       overrun_q;

   logic [6:0] n_len;
   logic       last_sample;
   logic [6:0] ones_new;
   logic [7:0] bipolar_new;
   logic [7:0] scaled;
   logic [3:0] prob4_new;

   assign n_len       = 7'd8 << win_q;
   assign last_sample = (sample_cnt == n_len - 7'd1);
   // Result includes the sample accepted on the loading edge.
   assign ones_new    = ones_cnt + {6'd0, bus.sn_bit};
   assign bipolar_new = {ones_new, 1'b0} - {1'b0, n_len};

   // ones*16/N reduces to a shift; the full window gives 16, hence saturation.
   always_comb begin
      scaled = 8'd0;
      case (win_q)
         2'd0:    scaled = {ones_new, 1'b0};
         2'd1:    scaled = {1'b0, ones_new};
         2'd2:    scaled = {2'b00, ones_new[6:1]};
         default: scaled = {3'b000, ones_new[6:2]};
      endcase
      prob4_new = (scaled > 8'd15) ? 4'd15 : scaled[3:0];
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      clr       = 1'b0;
      inc       = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nxt = ACCUM;
               arm       = 1'b1;
            end
         end
         ACCUM: begin
            // abort beats a coincident final sample
            if (bus.abort) begin
               state_nxt = IDLE;
               clr       = 1'b1;
            end else if (bus.sn_valid) begin
               if (last_sample) begin
                  load = 1'b1;
                  clr  = 1'b1;
                  if (!cont_q) state_nxt = IDLE;
               end else begin
                  inc = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         win_q      <= 2'd0;
         cont_q     <= 1'b0;
         sample_cnt <= 7'd0;
         ones_cnt   <= 7'd0;
      end else begin
         if (arm) begin
            win_q  <= bus.win_sel;
            cont_q <= bus.cont;
         end
         if (arm || clr) begin
            sample_cnt <= 7'd0;
            ones_cnt   <= 7'd0;
         end else if (inc) begin
            sample_cnt <= sample_cnt + 7'd1;
            ones_cnt   <= ones_new;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ones_q         <= 7'd0;
         bipolar_q      <= 8'd0;
         prob4_q        <= 4'd0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else if (load) begin
         ones_q         <= ones_new;
         bipolar_q      <= bipolar_new;
         prob4_q        <= prob4_new;
         result_valid_q <= 1'b1;
         // a coincident ack consumes the old result, so nothing is lost
         if (result_valid_q && !bus.result_ack) overrun_q <= 1'b1;
         else if (bus.result_ack)               overrun_q <= 1'b0;
      end else if (bus.result_ack && result_valid_q) begin
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end
   end

   assign bus.busy         = (state == ACCUM);
   assign bus.result_valid = result_valid_q;
   assign bus.ones_count   = ones_q;
   assign bus.bipolar      = bipolar_q;
   assign bus.prob4        = prob4_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sn_to_binary_accum.sv
module tb_sn_to_binary_accum;

   typedef struct packed {
      logic [6:0] ones;
      logic [7:0] bip;
      logic [3:0] p4;
   } res_t;

   logic clk;
   logic rst_n;
   sn_to_binary_accum_if bus();

   sn_to_binary_accum dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   res_t last;
   bit   m_busy;
   bit   m_cont;
   int   m_n, m_cnt, m_ones;
   bit   exp_rv, exp_ovr;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic res_t calc(input int ones, input int n);
      res_t r;
      int   b, p;
      b      = 2 * ones - n;
      p      = ones * 16 / n;
      if (p > 15) p = 15;
      r.ones = ones[6:0];
      r.bip  = b[7:0];
      r.p4   = p[3:0];
      return r;
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_cont  = 0;
      m_n     = 8;
      m_cnt   = 0;
      m_ones  = 0;
      exp_rv  = 0;
      exp_ovr = 0;
      last    = '0;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_busy"}, bus.busy, m_busy);
      chk({tag, "_rv"},   bus.result_valid, exp_rv);
      chk({tag, "_ovr"},  bus.overrun, exp_ovr);
      chk({tag, "_ones"}, bus.ones_count, last.ones);
      chk({tag, "_bip"},  bus.bipolar, last.bip);
      chk({tag, "_p4"},   bus.prob4, last.p4);
   endtask

   // Drive one cycle, advance the model, compare after the edge.
   task automatic step(input string tag, input bit v, input bit b,
                       input bit st, input bit ab, input bit ack);
      bit loaded;
      loaded         = 0;
      bus.sn_valid   = v;
      bus.sn_bit     = b;
      bus.start      = st;
      bus.abort      = ab;
      bus.result_ack = ack;
      if (!m_busy) begin
         if (st && !ab) begin
            m_busy = 1;
            m_n    = 8 << bus.win_sel;
            m_cont = bus.cont;
            m_cnt  = 0;
            m_ones = 0;
         end
      end else if (ab) begin
         m_busy = 0;
         m_cnt  = 0;
         m_ones = 0;
      end else if (v) begin
         m_cnt++;
         if (b) m_ones++;
         if (m_cnt == m_n) begin
            exp_q.push_back(calc(m_ones, m_n));
            if (exp_rv && !ack) exp_ovr = 1;
            else if (ack)       exp_ovr = 0;
            exp_rv = 1;
            loaded = 1;
            m_cnt  = 0;
            m_ones = 0;
            if (!m_cont) m_busy = 0;
         end
      end
      if (!loaded && ack && exp_rv) begin
         exp_rv  = 0;
         exp_ovr = 0;
      end
      @(posedge clk);
      #1;
      if (loaded) begin
         if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
         else last = exp_q.pop_front();
      end
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      #2 rst_n = 1'b1;
      #1;
      model_reset();
      check_outputs(tag);
      #2 rst_n = 1'b0;
   endtask

   int got;

   initial begin
      rst_n          = 1'b1;
      bus.sn_bit     = 0;
      bus.sn_valid   = 0;
      bus.start      = 0;
      bus.abort      = 0;
      bus.win_sel    = 0;
      bus.cont       = 0;
      bus.result_ack = 0;
      model_reset();
      #22;
      check_outputs("por");
      rst_n = 1'b0;

      // single all-ones window, N=8
      bus.win_sel = 0; bus.cont = 0;
      step("single_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) step("single", 1, 1, 0, 0, 0);
      chk("single_ones", bus.ones_count, 8);
      chk("single_bip", bus.bipolar, 8'd8);
      chk("single_p4", bus.prob4, 15);
      chk("single_busy", bus.busy, 0);
      step("idle_after", 1, 1, 0, 0, 0);

      // reset mid-window with result still pending
      bus.win_sel = 3;
      step("rst_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) step("rst_win", 1, 1, 0, 0, 0);
      do_reset("rst_mid");
      for (int i = 0; i < 70; i++) step("rst_after", 1, 1, 0, 0, 0);

      // gapped alternating stream, N=16; win_sel/cont changes during ACCUM ignored
      bus.win_sel = 1; bus.cont = 0;
      step("gap_start", 0, 0, 1, 0, 0);
      bus.win_sel = 0; bus.cont = 1;
      got = 0;
      for (int i = 0; i < 200 && got < 16; i++) begin
         if ($urandom_range(0, 2) == 0) step("gap_idle", 0, $urandom_range(0, 1), 0, 0, 0);
         else begin
            step("gap", 1, (got % 2) == 0, 1, 0, 0);
            got++;
         end
      end
      chk("gap_ones", bus.ones_count, 8);
      chk("gap_bip", bus.bipolar, 0);
      chk("gap_p4", bus.prob4, 8);
      step("gap_ack", 0, 0, 0, 0, 1);
      step("ack_noop", 0, 0, 0, 0, 1);

      // continuous, all-zero stream without ack -> overrun
      bus.win_sel = 0; bus.cont = 1;
      step("cont_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 16; i++) step("cont", 1, 0, 0, 0, 0);
      chk("cont_bip", bus.bipolar, 8'hF8);
      chk("cont_ovr", bus.overrun, 1);
      // ack on first sample of the next window; that sample still counts
      step("cont_ack", 1, 1, 0, 0, 1);
      for (int i = 0; i < 7; i++) step("cont_w3", 1, 1, 0, 0, 0);
      chk("cont_w3_ones", bus.ones_count, 8);
      // ack collides with the next load
      for (int i = 0; i < 7; i++) step("coll", 1, 1, 0, 0, 0);
      step("coll_load", 1, 0, 0, 0, 1);
      chk("coll_rv", bus.result_valid, 1);
      chk("coll_ovr", bus.overrun, 0);
      chk("coll_ones", bus.ones_count, 7);
      step("cont_abort", 1, 1, 0, 1, 0);

      // abort mid-window, N=32
      bus.win_sel = 2; bus.cont = 0;
      step("ab_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 20; i++) step("ab_win", 1, 1, 0, 0, 0);
      step("ab", 1, 1, 0, 1, 0);
      chk("ab_busy", bus.busy, 0);
      chk("ab_keep", bus.ones_count, 7);
      // abort coincident with the 32nd sample
      step("ab2_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 31; i++) step("ab2_win", 1, 1, 0, 0, 0);
      step("ab2_last", 1, 1, 0, 1, 0);
      chk("ab2_keep", bus.ones_count, 7);
      // abort in IDLE, start+abort together
      step("ab_idle", 0, 0, 0, 1, 0);
      step("st_ab", 0, 0, 1, 1, 0);
      step("ack_final", 0, 0, 0, 0, 1);
      // full N=64 window of ones
      bus.win_sel = 3;
      step("w64_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 64; i++) step("w64", 1, 1, 0, 0, 0);
      chk("w64_bip", bus.bipolar, 8'd64);
      chk("w64_p4", bus.prob4, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
